// File: rtl/phase_lock_pkg.sv
// Shared types and helpers for phase_lock_tracker.
//   phase_t     : 2-bit sampler phase (0..3)
//   state_t     : tracker FSM states
//   DIFF_*      : meaning of the mod-4 phase difference
//   phase_diff  : (a - b) mod 4
package phase_lock_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    localparam logic [1:0] DIFF_SAME  = 2'd0;
    localparam logic [1:0] DIFF_PLUS  = 2'd1;
    localparam logic [1:0] DIFF_GROSS = 2'd2;
    localparam logic [1:0] DIFF_MINUS = 2'd3;

    // 2-bit subtraction wraps naturally, giving the mod-4 difference.
    function automatic logic [1:0] phase_diff(phase_t a, phase_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/phase_lock_tracker_idle_timer.sv
// idle_timer: saturating cycle counter used to detect missing edges.
//   clk_i  : clock
//   rst_i  : asynchronous active-low reset
//   clr_i  : synchronous clear (priority over inc_i)
//   inc_i  : count this cycle
//   tc_o   : this cycle's increment brings the count to TIMEOUT_CYCLES
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] TC_MAX = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] TC_M1  = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // tc_o deliberately ignores clr_i: the owner raises clr_i in response
    // to tc_o, so gating here would form a combinational loop.
    assign tc_o = inc_i && (cnt_q == TC_M1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != TC_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/phase_lock_tracker.sv
// phase_lock_tracker: filters per-edge phase reports from the 4-phase
// sampler into a stable locked phase with hysteresis, single-step slip
// tracking, gross-error unlock and a timed holdover.
//   clk_i            : clk_0 domain clock
//   rst_i            : asynchronous active-low reset
//   clear_i          : synchronous restart to IDLE (beats phase_valid_i)
//   phase_i          : sampled phase 0..3
//   phase_valid_i    : qualifies phase_i
//   locked_o         : LOCKED or HOLDOVER
//   holdover_o       : HOLDOVER only
//   locked_phase_o   : current locked phase
//   slip_o           : one-cycle pulse on an accepted slip
//   slip_dir_o       : direction of last slip (1 = +1, 0 = -1)
// Optional (PHASE_LOCK_TRACKER_STATS_EN):
//   slip_total_o      : saturating accepted-slip count
//   lock_loss_total_o : saturating count of exits from lock
module phase_lock_tracker
    import phase_lock_pkg::*;
#(
    parameter int LOCK_COUNT     = 8,
    parameter int SLIP_COUNT     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  phase_t     phase_i,
    input  logic       phase_valid_i,
    output logic       locked_o,
    output logic       holdover_o,
    output phase_t     locked_phase_o,
    output logic       slip_o,
    output logic       slip_dir_o
`ifdef PHASE_LOCK_TRACKER_STATS_EN
    ,
    output logic [15:0] slip_total_o,
    output logic [15:0] lock_loss_total_o
`endif
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
    localparam logic [3:0] SLIP_N = 4'(SLIP_COUNT);

    state_t     state_q, state_d;
    phase_t     cand_q, cand_d;
    logic [7:0] match_q, match_d;
    phase_t     slip_tgt_q, slip_tgt_d;
    logic [3:0] slip_cnt_q, slip_cnt_d;
    phase_t     lphase_q, lphase_d;
    logic       slip_q, slip_d;
    logic       slip_dir_q, slip_dir_d;
    logic       locked_q, locked_d;
    logic       holdover_q, holdover_d;

    logic       in_lock;
    logic       tmr_clr, tmr_inc, tmr_tc;
    logic [1:0] diff;
    logic [3:0] slip_next;

    assign in_lock = (state_q == LOCKED) || (state_q == HOLDOVER);
    assign diff    = phase_diff(phase_i, lphase_q);

    // Timer only runs while locked and quiet; any sample, a state change
    // caused by timeout, or being out of lock restarts it.
    assign tmr_inc = in_lock && !phase_valid_i;
    assign tmr_clr = clear_i || !in_lock || phase_valid_i || tmr_tc;

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tmr_clr),
        .inc_i (tmr_inc),
        .tc_o  (tmr_tc)
    );

    // A different adjacent target (or a fresh slip run) restarts at 1.
    assign slip_next = (slip_cnt_q == 4'd0 || phase_i != slip_tgt_q)
                     ? 4'd1 : slip_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        match_d    = match_q;
        slip_tgt_d = slip_tgt_q;
        slip_cnt_d = slip_cnt_q;
        lphase_d   = lphase_q;
        slip_d     = 1'b0;
        slip_dir_d = slip_dir_q;

        unique case (state_q)
            IDLE: begin
                if (phase_valid_i) begin
                    state_d = ACQUIRE;
                    cand_d  = phase_i;
                    match_d = 8'd1;
                end
            end
            ACQUIRE: begin
                if (phase_valid_i) begin
                    if (phase_i != cand_q) begin
                        cand_d  = phase_i;
                        match_d = 8'd1;
                    end else if (match_q + 8'd1 >= LOCK_N) begin
                        state_d    = LOCKED;
                        lphase_d   = cand_q;
                        match_d    = 8'd0;
                        slip_cnt_d = 4'd0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (phase_valid_i) begin
                    unique case (diff)
                        DIFF_SAME: slip_cnt_d = 4'd0;
                        DIFF_GROSS: begin
                            state_d    = ACQUIRE;
                            cand_d     = phase_i;
                            match_d    = 8'd1;
                            slip_cnt_d = 4'd0;
                        end
                        default: begin
                            slip_tgt_d = phase_i;
                            if (slip_next == SLIP_N) begin
                                lphase_d   = phase_i;
                                slip_d     = 1'b1;
                                slip_dir_d = (diff == DIFF_PLUS);
                                slip_cnt_d = 4'd0;
                            end else begin
                                slip_cnt_d = slip_next;
                            end
                        end
                    endcase
                end else if (tmr_tc) begin
                    state_d    = HOLDOVER;
                    slip_cnt_d = 4'd0;
                end
            end
            HOLDOVER: begin
                // Phase is frozen here: any non-matching sample re-acquires.
                if (phase_valid_i) begin
                    if (diff == DIFF_SAME) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = ACQUIRE;
                        cand_d  = phase_i;
                        match_d = 8'd1;
                    end
                end else if (tmr_tc) begin
                    state_d    = IDLE;
                    lphase_d   = '0;
                    slip_dir_d = 1'b0;
                    match_d    = 8'd0;
                    slip_cnt_d = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            cand_d     = '0;
            match_d    = 8'd0;
            slip_tgt_d = '0;
            slip_cnt_d = 4'd0;
            lphase_d   = '0;
            slip_d     = 1'b0;
            slip_dir_d = 1'b0;
        end
    end

    assign locked_d   = (state_d == LOCKED) || (state_d == HOLDOVER);
    assign holdover_d = (state_d == HOLDOVER);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            match_q    <= 8'd0;
            slip_tgt_q <= '0;
            slip_cnt_q <= 4'd0;
            lphase_q   <= '0;
            slip_q     <= 1'b0;
            slip_dir_q <= 1'b0;
            locked_q   <= 1'b0;
            holdover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            match_q    <= match_d;
            slip_tgt_q <= slip_tgt_d;
            slip_cnt_q <= slip_cnt_d;
            lphase_q   <= lphase_d;
            slip_q     <= slip_d;
            slip_dir_q <= slip_dir_d;
            locked_q   <= locked_d;
            holdover_q <= holdover_d;
        end
    end

    assign locked_o       = locked_q;
    assign holdover_o     = holdover_q;
    assign locked_phase_o = lphase_q;
    assign slip_o         = slip_q;
    assign slip_dir_o     = slip_dir_q;

`ifdef PHASE_LOCK_TRACKER_STATS_EN
    logic [15:0] slip_tot_q, slip_tot_d;
    logic [15:0] loss_tot_q, loss_tot_d;
    logic        lost;

    // clear_i zeroes the counters, so a clear-induced exit is not counted.
    assign lost = in_lock && (state_d == ACQUIRE || state_d == IDLE);

    always_comb begin
        slip_tot_d = slip_tot_q;
        loss_tot_d = loss_tot_q;
        if (clear_i) begin
            slip_tot_d = 16'd0;
            loss_tot_d = 16'd0;
        end else begin
            if (slip_d && slip_tot_q != 16'hFFFF) slip_tot_d = slip_tot_q + 16'd1;
            if (lost && loss_tot_q != 16'hFFFF)   loss_tot_d = loss_tot_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            slip_tot_q <= 16'd0;
            loss_tot_q <= 16'd0;
        end else begin
            slip_tot_q <= slip_tot_d;
            loss_tot_q <= loss_tot_d;
        end
    end

    assign slip_total_o      = slip_tot_q;
    assign lock_loss_total_o = loss_tot_q;
`endif

endmodule

// File: doc/phase_lock_tracker.md
Name: phase_lock_tracker

Overview:
- Downstream consumer of the 4-phase shifted-clock sampler.
- Runs in the clk_0 domain, fed directly by the sampler's phase and phase_valid outputs.
- Filters raw per-edge phase reports into a stable locked phase with hysteresis.
- Tracks single-step phase slips, declares loss of lock on gross errors, and holds over briefly when edges stop arriving.

Parameters:
- LOCK_COUNT, 8: consecutive identical valid phases required to declare lock; range 2..255.
- SLIP_COUNT, 3: consecutive valid phases at the same adjacent (±1 mod 4) value required to accept a slip; range 1..15.
- TIMEOUT_CYCLES, 1024: cycles without phase_valid before LOCKED goes to HOLDOVER, and again before HOLDOVER goes to IDLE; minimum 2.

Ports:
- clk  input  1  clock; the sampler's clk_0 domain.
- rst  input  1  asynchronous, active-low reset; rst=0 resets all state.
- clear  input  1  synchronous restart to IDLE; same effect as reset, one cycle later.
- phase  input  2  sampled phase, 0..3.
- phase_valid  input  1  qualifies phase for one cycle.
- locked  output  1  high in LOCKED and HOLDOVER.
- holdover  output  1  high in HOLDOVER only.
- locked_phase  output  2  current locked phase; valid while locked=1.
- slip  output  1  one-cycle pulse when an accepted slip updates locked_phase.
- slip_dir  output  1  direction of the last slip: 1 = +1 mod 4, 0 = -1 mod 4. Held until the next slip.

Behaviour:
- Reset/clear values: all outputs 0; state IDLE; all counters 0.
- All outputs are registered. Decisions appear the cycle after the deciding phase_valid.
- Phase difference: diff = (phase - locked_phase) mod 4 in 2 bits. diff 1 = +1, diff 3 = -1, diff 2 = gross error.
- IDLE:
  - First phase_valid: candidate <= phase, match_cnt <= 1, go to ACQUIRE.
- ACQUIRE:
  - valid with phase == candidate: match_cnt++.
  - valid with phase != candidate: candidate <= phase, match_cnt <= 1.
  - When the increment makes match_cnt reach LOCK_COUNT: go to LOCKED, locked_phase <= candidate, locked=1 on the next cycle.
  - No timeout in ACQUIRE; the tracker waits indefinitely.
- LOCKED:
  - valid, diff 0: slip_cnt <= 0, idle timer <= 0.
  - valid, diff 1 or 3: if slip_cnt == 0 or the slip target differs from the current phase, slip_target <= phase and slip_cnt <= 1; else slip_cnt++.
  - When slip_cnt reaches SLIP_COUNT: locked_phase <= slip_target, slip pulses, slip_dir is set, slip_cnt <= 0.
  - valid, diff 2: drop lock immediately; go to ACQUIRE with candidate <= phase and match_cnt <= 1; locked=0 next cycle.
  - Idle timer counts cycles without valid; any valid clears it.
  - Timer reaching TIMEOUT_CYCLES: go to HOLDOVER, timer <= 0.
- HOLDOVER:
  - locked_phase is frozen; locked=1 and holdover=1.
  - valid, diff 0: return to LOCKED.
  - valid, diff 1 or 3: go to ACQUIRE seeded with phase; no slip is accepted in HOLDOVER.
  - valid, diff 2: go to ACQUIRE seeded with phase.
  - Timer reaching TIMEOUT_CYCLES again: go to IDLE, all outputs 0.
- Simultaneous events:
  - clear overrides phase_valid in the same cycle.
  - A slip and a gross error cannot coincide, because each cycle carries one sample.
- Counters:
  - match_cnt is 8 bits and saturates at LOCK_COUNT.
  - slip_cnt is 4 bits.
  - The idle timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
- Asserting reset mid-slip or mid-acquire discards all partial counts.

Optional Feature:
- Macro: PHASE_LOCK_TRACKER_STATS_EN.
- When defined, two extra outputs are added:
  - slip_total, 16-bit: saturating count of accepted slips.
  - lock_loss_total, 16-bit: saturating count of exits from LOCKED/HOLDOVER to ACQUIRE or IDLE.
- Both counters are cleared by reset and clear, and are not cleared by re-lock.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package phase_lock_pkg contains:
  - phase_t, a 2-bit typedef.
  - state_t enum: IDLE, ACQUIRE, LOCKED, HOLDOVER.
  - Function phase_diff(phase_t a, phase_t b) returning a 2-bit mod-4 difference.
  - Constants DIFF_SAME=0, DIFF_PLUS=1, DIFF_GROSS=2, DIFF_MINUS=3.
- Sub-module idle_timer: saturating timer with clear, increment, and a terminal-count flag at TIMEOUT_CYCLES. Instanced once.

Test Plan:
- Lock: 8 valids of phase=2, one every 4 cycles -> locked=1 and locked_phase=2 the cycle after the 8th; still locked=0 after the 7th.
- Acquire restart: phases 1,1,1,3,3,3,3,3,3,3,3 -> lock on 3 only after the 8th 3; candidate resets at the first 3.
- Slip: locked on 0, then phases 1,1,1 -> slip pulse for one cycle, slip_dir=1, locked_phase=1. Sequence 1,3,1 -> no slip.
- Gross error: locked on 1, then a single valid phase=3 -> locked=0 next cycle, state ACQUIRE with candidate 3.
- Holdover: TIMEOUT_CYCLES=16, locked on 2, no valid for 16 cycles -> holdover=1. A phase=2 valid returns to LOCKED. Another 32 idle cycles -> IDLE with all outputs 0.
- Reset/clear: assert rst=0 mid-ACQUIRE (match_cnt=5), or pulse clear in the same cycle as a valid -> all outputs 0, and a full 8 samples are required to lock again.
